// File: rtl/fir_mac_scheduler.sv
// Round-robin scheduler sharing one MAC between NUM_CH FIR channels:
// walks the taps, drains the MAC pipeline, then writes the scaled result and acks.
//
// state | meaning
// IDLE  | pick next requester round-robin, no channel owns the MAC
// RUN   | walk taps 0..TAPS-1 with mac_en high
// DRAIN | wait MAC_LAT cycles for the accumulator to settle
// DONE  | write scaled result to output FIFO once y_full is low, then ack
module fir_mac_scheduler #(
    parameter int NUM_CH     = 2,
    parameter int TAPS       = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 48,
    parameter int FRAC_BITS  = 10,
    parameter int MAC_LAT    = 2,
    localparam int TW  = (TAPS > 1) ? $clog2(TAPS) : 1,
    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int DRW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           req_i,
    output logic [NUM_CH-1:0]           ack_o,
    output logic [NUM_CH-1:0]           grant_o,
    output logic [TW-1:0]               tap_idx_o,
    output logic                        mac_en_o,
    output logic                        mac_clr_o,
    output logic                        mac_last_o,
    input  logic signed [ACC_WIDTH-1:0] mac_acc_i,
    output logic [DATA_WIDTH-1:0]       y_out_o,
    output logic [CW-1:0]               y_ch_o,
    output logic                        y_wr_en_o,
    input  logic                        y_full_i
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                      state_q;
    logic [NUM_CH-1:0]           grant_q, ack_q;
    logic [TW-1:0]               tap_q;
    logic [DRW-1:0]              drain_q;
    logic [CW-1:0]               ch_q, last_q, y_ch_q;
    logic                        mac_en_q, mac_clr_q, mac_last_q, y_wr_en_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0]       y_out_q;

    logic                        pick_found_d;
    logic [CW-1:0]               pick_idx_d;
    logic [DATA_WIDTH-1:0]       y_scaled_d;

    // First set request searching upward from the channel after last_served.
    always_comb begin
        int c;
        c            = 0;
        pick_found_d = 1'b0;
        pick_idx_d   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            c = (int'(last_q) + i) % NUM_CH;
            if (!pick_found_d && req_i[c]) begin
                pick_found_d = 1'b1;
                pick_idx_d   = CW'(c);
            end
        end
    end

    assign y_scaled_d = DATA_WIDTH'(acc_q >>> FRAC_BITS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            tap_q      <= '0;
            drain_q    <= '0;
            ch_q       <= '0;
            last_q     <= CW'(NUM_CH - 1);
            y_ch_q     <= '0;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_last_q <= 1'b0;
            y_wr_en_q  <= 1'b0;
            acc_q      <= '0;
            y_out_q    <= '0;
        end else begin
            ack_q     <= '0;
            y_wr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_found_d) begin
                        grant_q    <= NUM_CH'(1) << pick_idx_d;
                        ch_q       <= pick_idx_d;
                        tap_q      <= '0;
                        mac_en_q   <= 1'b1;
                        mac_clr_q  <= 1'b1;
                        mac_last_q <= (TAPS == 1);
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (tap_q == TW'(TAPS - 1)) begin
                        tap_q      <= '0;
                        mac_en_q   <= 1'b0;
                        mac_clr_q  <= 1'b0;
                        mac_last_q <= 1'b0;
                        if (MAC_LAT == 0) begin
                            acc_q   <= mac_acc_i;
                            state_q <= DONE;
                        end else begin
                            drain_q <= DRW'(MAC_LAT - 1);
                            state_q <= DRAIN;
                        end
                    end else begin
                        tap_q      <= tap_q + 1'b1;
                        mac_clr_q  <= 1'b0;
                        mac_last_q <= (tap_q == TW'(TAPS - 2));
                    end
                end
                DRAIN: begin
                    // Capture on DONE entry so a full FIFO cannot corrupt the result.
                    if (drain_q == '0) begin
                        acc_q   <= mac_acc_i;
                        state_q <= DONE;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                DONE: begin
                    if (!y_full_i) begin
                        y_wr_en_q <= 1'b1;
                        ack_q     <= grant_q;
                        y_out_q   <= y_scaled_d;
                        y_ch_q    <= ch_q;
                        last_q    <= ch_q;
                        grant_q   <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o      = ack_q;
    assign grant_o    = grant_q;
    assign tap_idx_o  = tap_q;
    assign mac_en_o   = mac_en_q;
    assign mac_clr_o  = mac_clr_q;
    assign mac_last_o = mac_last_q;
    assign y_out_o    = y_out_q;
    assign y_ch_o     = y_ch_q;
    assign y_wr_en_o  = y_wr_en_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler with a one-stage-delayed MAC model
// (accumulator updates MAC_LAT=2 cycles after mac_en is presented).
module tb_fir_mac_scheduler;

    logic               clock = 1'b0;
    logic               reset;
    logic [1:0]         req, ack, grant;
    logic [4:0]         tap_idx;
    logic               mac_en, mac_clr, mac_last;
    logic signed [47:0] mac_acc;
    logic [31:0]        y_out;
    logic [0:0]         y_ch;
    logic               y_wr_en, y_full;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    fir_mac_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .req_i      (req),
        .ack_o      (ack),
        .grant_o    (grant),
        .tap_idx_o  (tap_idx),
        .mac_en_o   (mac_en),
        .mac_clr_o  (mac_clr),
        .mac_last_o (mac_last),
        .mac_acc_i  (mac_acc),
        .y_out_o    (y_out),
        .y_ch_o     (y_ch),
        .y_wr_en_o  (y_wr_en),
        .y_full_i   (y_full)
    );

    // MAC model: product = tap_idx*1024
    logic               s1_en, s1_clr;
    logic [4:0]         s1_tap;
    logic signed [47:0] model_acc, const_acc;
    logic               use_const;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_en <= 1'b0; s1_clr <= 1'b0; s1_tap <= '0; model_acc <= '0;
        end else begin
            s1_en  <= mac_en;
            s1_clr <= mac_clr;
            s1_tap <= tap_idx;
            if (s1_en)
                model_acc <= (s1_clr ? 48'sd0 : model_acc) + 48'(s1_tap) * 48'sd1024;
        end
    end

    assign mac_acc = use_const ? const_acc : model_acc;

    always @(negedge clock) begin
        if (!reset) begin
            checks++;
            if (!$onehot0(grant) || !$onehot0(ack) || ((ack != 2'b00) !== y_wr_en)) begin
                errors++;
                $display("FAIL invariant t=%0t grant=%b ack=%b y_wr_en=%b", $time, grant, ack, y_wr_en);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({ack, grant, tap_idx, mac_en, mac_clr, mac_last, y_out, y_ch, y_wr_en} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got grant=%b tap=%0d en=%b y_out=%h wr=%b, required all 0",
                     grant, tap_idx, mac_en, y_out, y_wr_en);
        end
        repeat (3) @(negedge clock);
        checks++;
        if ({ack, grant, mac_en, y_wr_en} !== '0) begin
            errors++;
            $display("FAIL reset_held got grant=%b ack=%b en=%b wr=%b, required 0", grant, ack, mac_en, y_wr_en);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [12:0] obs, expv;
        do_reset();
        use_const = 1'b0;
        req = 2'b01;
        for (int c = 0; c <= 37; c++) begin
            @(negedge clock);
            expv = {(c <= 34) ? 2'b01 : 2'b00, (c <= 31) ? 5'(c) : 5'd0, c <= 31, c == 0, c == 31,
                    (c == 35) ? 2'b01 : 2'b00, c == 35};
            obs  = {grant, tap_idx, mac_en, mac_clr, mac_last, ack, y_wr_en};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL single c=%0d got {grant,tap,en,clr,last,ack,wr}=%b required %b", c, obs, expv);
            end
            if (c == 35) begin
                checks++;
                if (y_out !== 32'd496 || y_ch !== 1'b0) begin
                    errors++;
                    $display("FAIL single_result got y_out=%0d y_ch=%0d required 496 ch 0", y_out, y_ch);
                end
                req = 2'b00;
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0] order [4];
        logic [1:0] exp_order [4];
        int n_ack, idle_run;
        bit had_grant;
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
        n_ack = 0; idle_run = 0; had_grant = 0;
        do_reset();
        req = 2'b11;
        for (int c = 0; c < 400 && n_ack < 4; c++) begin
            @(negedge clock);
            if (ack != 2'b00) begin
                order[n_ack] = ack;
                n_ack++;
            end
            if (grant == 2'b00) begin
                idle_run++;
            end else begin
                if (had_grant && idle_run != 0) begin
                    checks++;
                    if (idle_run != 1) begin
                        errors++;
                        $display("FAIL contention_gap got %0d idle cycles required 1", idle_run);
                    end
                end
                idle_run  = 0;
                had_grant = 1;
            end
        end
        checks++;
        if (n_ack != 4) begin
            errors++;
            $display("FAIL contention_timeout got %0d acks required 4", n_ack);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (order[i] !== exp_order[i]) begin
                    errors++;
                    $display("FAIL contention_order idx=%0d got ack=%b required %b", i, order[i], exp_order[i]);
                end
            end
        end
        req = 2'b00;
    endtask

    task automatic test_backpressure();
        do_reset();
        use_const = 1'b0;
        req = 2'b01;
        for (int c = 0; c <= 41; c++) begin
            @(negedge clock);
            if (c == 34) y_full = 1'b1;
            if (c == 35) begin
                // Disturb the MAC output while stalled; the captured value must win.
                const_acc = 48'sh0123_4567_89AB;
                use_const = 1'b1;
            end
            if (c >= 35 && c <= 39) begin
                checks++;
                if (y_wr_en !== 1'b0 || ack !== 2'b00 || grant !== 2'b01) begin
                    errors++;
                    $display("FAIL backpressure_stall c=%0d got wr=%b ack=%b grant=%b required 0 00 01",
                             c, y_wr_en, ack, grant);
                end
            end
            if (c == 39) y_full = 1'b0;
            if (c == 40) begin
                checks++;
                if (y_wr_en !== 1'b1 || ack !== 2'b01 || y_out !== 32'd496) begin
                    errors++;
                    $display("FAIL backpressure_write got wr=%b ack=%b y_out=%0d required 1 01 496",
                             y_wr_en, ack, y_out);
                end
                req = 2'b00;
            end
        end
        use_const = 1'b0;
    endtask

    task automatic test_scale();
        logic signed [47:0] acc_v [6];
        logic [31:0]        y_v   [6];
        int lat;
        acc_v = '{-48'sd5000, 48'sd5000, -48'sd1024, -48'sd1, 48'sd1023, 48'sh7123_4567_89AB};
        y_v   = '{32'hFFFF_FFFB, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h48D1_59E2};
        do_reset();
        for (int v = 0; v < 6; v++) begin
            const_acc = acc_v[v];
            use_const = 1'b1;
            req = 2'b10;
            lat = -1;
            for (int c = 0; c < 60; c++) begin
                @(negedge clock);
                if (y_wr_en) begin
                    lat = c;
                    break;
                end
            end
            checks++;
            if (lat != 35 || y_out !== y_v[v] || y_ch !== 1'b1 || ack !== 2'b10) begin
                errors++;
                $display("FAIL scale v=%0d got lat=%0d y_out=%h ch=%0d ack=%b required 35 %h 1 10",
                         v, lat, y_out, y_ch, ack, y_v[v]);
            end
            req = 2'b00;
            @(negedge clock);
        end
        use_const = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bool_t_dummy: begin end
        do_reset();
        use_const = 1'b0;
        req = 2'b01;
        for (int c = 0; c <= 10; c++) @(negedge clock);
        checks++;
        if (tap_idx !== 5'd10 || grant !== 2'b01) begin
            errors++;
            $display("FAIL midrun_pre got tap=%0d grant=%b required 10 01", tap_idx, grant);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ack, grant, tap_idx, mac_en, mac_clr, mac_last, y_out, y_ch, y_wr_en} !== '0) begin
            errors++;
            $display("FAIL midrun_abort got grant=%b tap=%0d en=%b wr=%b required all 0",
                     grant, tap_idx, mac_en, y_wr_en);
        end
        req = 2'b10;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c <= 36; c++) begin
            @(negedge clock);
            if (c == 0) begin
                checks++;
                if (grant !== 2'b10 || tap_idx !== 5'd0 || mac_clr !== 1'b1 || mac_en !== 1'b1) begin
                    errors++;
                    $display("FAIL midrun_restart got grant=%b tap=%0d clr=%b en=%b required 10 0 1 1",
                             grant, tap_idx, mac_clr, mac_en);
                end
            end
            if (c < 35 && ack !== 2'b00) begin
                checks++;
                errors++;
                $display("FAIL midrun_stray_ack c=%0d got ack=%b required 00", c, ack);
            end
            if (c == 35) begin
                checks++;
                if (ack !== 2'b10 || y_ch !== 1'b1 || y_out !== 32'd496) begin
                    errors++;
                    $display("FAIL midrun_result got ack=%b ch=%0d y_out=%0d required 10 1 496",
                             ack, y_ch, y_out);
                end
                req = 2'b00;
            end
        end
    endtask

    initial begin
        req       = 2'b00;
        y_full    = 1'b0;
        use_const = 1'b0;
        const_acc = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_scale();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
